chacha_core: RTL and testbench

- Iterative ChaCha block engine that consumes the 512-bit `key` and `plaintext` words assembled by the SPI front end. It returns `cyphertext` and the `done` flag to that front end.
- Computes `cyphertext = plaintext XOR (ChaChaRounds(key) + key)`, word-wise. `key` is the full 16-word initial ChaCha state: constants, key, counter and nonce, all formatted by the MCU.
- Runs in the system `clk` domain, triggered by the MCU `load` strobe, at one round per clock.

---
 rtl/chacha_core.sv | 172 +++++++++++++++++
 tb/tb_chacha_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_core.sv
// chacha_core: iterative ChaCha block engine, one round per clock.
//   cyphertext = plaintext ^ (ChaChaRounds(key) + key), word-wise.
//   Word i of every 512-bit bus is bits [511-32i -: 32], no byte swapping.
// Optional feature macro: CHACHA_LOAD_SYNC_EN
//   defined   -> `load` passes through a two-flop synchronizer before the FSM
//   undefined -> `load` feeds the FSM directly (must already be clk-synchronous)
//
// Handshake: there is no valid/ready pair. A transaction starts on the falling
// edge of `load` (as seen by the FSM). `done` is a registered level that rises
// once per transaction and stays high, with `cyphertext`, until `load` rises
// again. Operands must remain stable from `load` falling until `done`.
module chacha_core #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [511:0] key,
  input  logic [511:0] plaintext,
  output logic [511:0] cyphertext,
  output logic         done,
  output logic [2:0]   dbg_state_o
);

  localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [RW-1:0]   rnd_q;
  logic [31:0]     x_q    [16];
  logic [31:0]     init_q [16];
  logic [31:0]     x_d    [16];
  logic [511:0]    cyph_q;
  logic            done_q;
  logic            load_s;

`ifdef CHACHA_LOAD_SYNC_EN
  logic [1:0] load_sync_q;

  // Two-flop synchronizer bringing the asynchronous MCU strobe into clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_sync_q <= 2'b00;
    end else begin
      load_sync_q <= {load_sync_q[0], load};
    end
  end

  assign load_s = load_sync_q[1];
`else
  assign load_s = load;
`endif

  // ChaCha quarter-round on one (a,b,c,d) set, returned as {a,b,c,d}
  function automatic logic [127:0] quarter_round(input logic [31:0] a_i,
                                                 input logic [31:0] b_i,
                                                 input logic [31:0] c_i,
                                                 input logic [31:0] d_i);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    a = a_i;
    b = b_i;
    c = c_i;
    d = d_i;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // One full round: column round on even rnd, diagonal round on odd rnd
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      x_d[i] = x_q[i];
    end
    if (!rnd_q[0]) begin
      {x_d[0], x_d[4], x_d[8],  x_d[12]} = quarter_round(x_q[0], x_q[4], x_q[8],  x_q[12]);
      {x_d[1], x_d[5], x_d[9],  x_d[13]} = quarter_round(x_q[1], x_q[5], x_q[9],  x_q[13]);
      {x_d[2], x_d[6], x_d[10], x_d[14]} = quarter_round(x_q[2], x_q[6], x_q[10], x_q[14]);
      {x_d[3], x_d[7], x_d[11], x_d[15]} = quarter_round(x_q[3], x_q[7], x_q[11], x_q[15]);
    end else begin
      {x_d[0], x_d[5], x_d[10], x_d[15]} = quarter_round(x_q[0], x_q[5], x_q[10], x_q[15]);
      {x_d[1], x_d[6], x_d[11], x_d[12]} = quarter_round(x_q[1], x_q[6], x_q[11], x_q[12]);
      {x_d[2], x_d[7], x_d[8],  x_d[13]} = quarter_round(x_q[2], x_q[7], x_q[8],  x_q[13]);
      {x_d[3], x_d[4], x_d[9],  x_d[14]} = quarter_round(x_q[3], x_q[4], x_q[9],  x_q[14]);
    end
  end

  // Control FSM with the working state, round counter and registered outputs.
  // A rising load_s during RUN or FINAL aborts: the partial state is simply
  // overwritten at the next capture and the old cyphertext is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      done_q  <= 1'b0;
      cyph_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        x_q[i]    <= '0;
        init_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_s) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!load_s) begin
            for (int i = 0; i < 16; i++) begin
              x_q[i]    <= key[511-32*i -: 32];
              init_q[i] <= key[511-32*i -: 32];
            end
            rnd_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (load_s) begin
            state_q <= S_LOAD;
          end else begin
            for (int i = 0; i < 16; i++) begin
              x_q[i] <= x_d[i];
            end
            if (rnd_q == RW'(ROUNDS - 1)) begin
              rnd_q   <= '0;
              state_q <= S_FINAL;
            end else begin
              rnd_q <= rnd_q + 1'b1;
            end
          end
        end
        S_FINAL: begin
          if (load_s) begin
            state_q <= S_LOAD;
          end else begin
            for (int i = 0; i < 16; i++) begin
              cyph_q[511-32*i -: 32] <= plaintext[511-32*i -: 32] ^ (x_q[i] + init_q[i]);
            end
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (load_s) begin
            done_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cyphertext  = cyph_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_chacha_core.sv
// tb_chacha_core: scoreboard bench for chacha_core (ROUNDS=20 and ROUNDS=2).
// Honours CHACHA_LOAD_SYNC_EN the same way as the design for latency checks.
module tb_chacha_core;

`ifdef CHACHA_LOAD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT20  = 20 + 2 + SYNC_LAT;
  localparam int LAT2   = 2 + 2 + SYNC_LAT;
  localparam int E0_IDX = 1 + SYNC_LAT;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         load;
  logic         load2;
  logic [511:0] key;
  logic [511:0] plaintext;
  logic [511:0] cyph20;
  logic [511:0] cyph2;
  logic         done20;
  logic         done2;
  logic [2:0]   st20;
  logic [2:0]   st2;

  int checks = 0;
  int errors = 0;

  logic [511:0] exp_q[$];
  logic [511:0] exp2_q[$];

  logic [511:0] rfc_key;
  logic [511:0] held;

  chacha_core #(.ROUNDS(20)) dut (
    .clk(clk), .reset(reset), .load(load), .key(key), .plaintext(plaintext),
    .cyphertext(cyph20), .done(done20), .dbg_state_o(st20)
  );

  chacha_core #(.ROUNDS(2)) dut2 (
    .clk(clk), .reset(reset), .load(load2), .key(key), .plaintext(plaintext),
    .cyphertext(cyph2), .done(done2), .dbg_state_o(st2)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // checker
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] model(input logic [511:0] k, input logic [511:0] p,
                                         input int rounds);
    logic [31:0] s [16];
    logic [31:0] s0 [16];
    logic [31:0] a, b, c, d;
    logic [511:0] res;
    int ia, ib, ic, id;
    for (int i = 0; i < 16; i++) begin
      s[i]  = k[511-32*i -: 32];
      s0[i] = s[i];
    end
    for (int r = 0; r < rounds; r++) begin
      for (int j = 0; j < 4; j++) begin
        ia = j;
        if (r % 2 == 0) begin
          ib = j + 4; ic = j + 8; id = j + 12;
        end else begin
          ib = 4 + (j + 1) % 4; ic = 8 + (j + 2) % 4; id = 12 + (j + 3) % 4;
        end
        a = s[ia]; b = s[ib]; c = s[ic]; d = s[id];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        s[ia] = a; s[ib] = b; s[ic] = c; s[id] = d;
      end
    end
    for (int i = 0; i < 16; i++) begin
      res[511-32*i -: 32] = p[511-32*i -: 32] ^ (s[i] + s0[i]);
    end
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) begin
      v[32*i +: 32] = $urandom();
    end
    return v;
  endfunction

  // driver tasks
  task automatic set_load(input bit sel2, input logic val);
    @(negedge clk);
    if (sel2) load2 = val;
    else      load  = val;
  endtask

  task automatic wait_done(input bit sel2, input int lat_exp, input string tag);
    int n;
    bit got;
    logic [511:0] e;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (sel2 ? done2 : done20) got = 1'b1;
    end
    chk({tag, "_done"}, got, 1'b1);
    if (got) begin
      chk({tag, "_lat"}, n, lat_exp);
      if (sel2) begin
        chk({tag, "_sbq"}, exp2_q.size(), 1);
        if (exp2_q.size() > 0) begin
          e = exp2_q.pop_front();
          chk({tag, "_cyph"}, cyph2, e);
        end
      end else begin
        chk({tag, "_sbq"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, "_cyph"}, cyph20, e);
        end
      end
    end
  endtask

  task automatic run_txn(input logic [511:0] k, input logic [511:0] p, input bit sel2,
                         input string tag);
    key = k;
    plaintext = p;
    if (sel2) exp2_q.push_back(model(k, p, 2));
    else      exp_q.push_back(model(k, p, 20));
    set_load(sel2, 1'b1);
    repeat (4) @(negedge clk);
    if (sel2) load2 = 1'b0;
    else      load  = 1'b0;
    wait_done(sel2, lat_exp_of(sel2), tag);
  endtask

  function automatic int lat_exp_of(input bit sel2);
    return sel2 ? LAT2 : LAT20;
  endfunction

  // main sequence
  initial begin
    int n;
    logic [511:0] k, p;
    rfc_key = {32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
               32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
               32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
               32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    reset = 1'b1;
    load = 1'b0;
    load2 = 1'b0;
    key = '0;
    plaintext = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done20, 1'b0);
    chk("rst_cyph", cyph20, '0);
    chk("rst_state", st20, 3'd0);
    chk("rst_done2", done2, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // RFC 7539 block function vector
    run_txn(rfc_key, '0, 1'b0, "rfc");
    chk("rfc_words", cyph20[511:384],
        {32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3});

    // hold after done
    held = cyph20;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk("hold_cyph", cyph20, held);
      chk("hold_done", done20, 1'b1);
    end

    // all-zero key
    run_txn('0, {64{8'hA5}}, 1'b0, "zero");
    chk("zero_pat", cyph20, {64{8'hA5}});

    // clear on load rise, then a new transaction
    held = cyph20;
    k = rand512();
    p = rand512();
    key = k;
    plaintext = p;
    exp_q.push_back(model(k, p, 20));
    set_load(1'b0, 1'b1);
    n = 0;
    while (done20 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clr_within3", (n <= 3), 1'b1);
    chk("clr_cyph", cyph20, held);
    repeat (2) @(negedge clk);
    load = 1'b0;
    wait_done(1'b0, LAT20, "clr_next");

    // abort at E10, then a fresh transaction with new operands
    key = rand512();
    plaintext = rand512();
    set_load(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    load = 1'b0;
    repeat (E0_IDX + 10) @(posedge clk);
    #1;
    load = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      chk("abort_done", done20, 1'b0);
    end
    k = rand512();
    p = rand512();
    key = k;
    plaintext = p;
    exp_q.push_back(model(k, p, 20));
    @(negedge clk);
    load = 1'b0;
    wait_done(1'b0, LAT20, "abort_new");

    // asynchronous reset at E7
    held = cyph20;
    chk("pre_rst_nonzero", (held != '0), 1'b1);
    key = rand512();
    plaintext = rand512();
    set_load(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    load = 1'b0;
    repeat (E0_IDX + 7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_done", done20, 1'b0);
    chk("rst_mid_cyph", cyph20, '0);
    chk("rst_mid_state", st20, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(rand512(), rand512(), 1'b0, "post_rst");

    // random transactions
    for (int i = 0; i < 3; i++) begin
      run_txn(rand512(), rand512(), 1'b0, "rand");
    end

    // ROUNDS=2 instance
    run_txn(rfc_key, '0, 1'b1, "r2_rfc");
    run_txn(rand512(), rand512(), 1'b1, "r2_rand");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
